// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - Shared FSM states, reset cause codes and cause priority for rst_seq_gen.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_POR     = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    localparam logic [2:0] CAUSE_POR = 3'b000;
    localparam logic [2:0] CAUSE_KEY = 3'b001;
    localparam logic [2:0] CAUSE_PLL = 3'b010;
    localparam logic [2:0] CAUSE_SW  = 3'b011;
    localparam logic [2:0] CAUSE_WDT = 3'b100;

    // Larger rank wins when a new trigger arrives while already holding.
    function automatic logic [2:0] cause_rank(input logic [2:0] cause);
        case (cause)
            CAUSE_PLL: return 3'd4;
            CAUSE_KEY: return 3'd3;
            CAUSE_SW:  return 3'd2;
            CAUSE_WDT: return 3'd1;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// rtl/rst_seq_debounce.sv - Input synchroniser with optional debounce; emits level and press (1->0) pulse.
module rst_seq_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 1) begin : g_pass
            // No filtering: the level is the synchronised input itself.
            logic r_prev;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= w_sync;
                end
            end

            assign o_level = w_sync;
            assign o_press = r_prev & ~w_sync;
        end else begin : g_deb
            localparam int         CW   = $clog2(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_level;
            logic          r_press;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt   <= '0;
                    r_level <= 1'b1;
                    r_press <= 1'b0;
                end else begin
                    r_press <= 1'b0;
                    if (w_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_level <= w_sync;
                        r_press <= r_level & ~w_sync;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign o_level = r_level;
            assign o_press = r_press;
        end
    endgenerate

endmodule

// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - Ordered multi-channel reset sequencer with cause latch; watchdog under RST_SEQ_WDT_EN.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH          = 3,
    parameter int POR_CYCLES      = 1024,
    parameter int SW_RST_CYCLES   = 16,
    parameter int STAGE_GAP       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int WDT_CYCLES      = 2**24
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              key_n_i,
    input  logic              pll_locked_i,
    input  logic              sw_rst_req_i,
    input  logic              wdt_kick_i,
    output logic [NUM_CH-1:0] rst_o,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              ready_o,
    output logic [2:0]        cause_o
);

    localparam int HOLD_MAX = (POR_CYCLES > SW_RST_CYCLES) ? POR_CYCLES : SW_RST_CYCLES;
    localparam int CNT_W    = (HOLD_MAX > 1)  ? $clog2(HOLD_MAX)  : 1;
    localparam int GAP_W    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W    = (NUM_CH > 1)    ? $clog2(NUM_CH)    : 1;

    localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LOAD  = CNT_W'(SW_RST_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    state_t             r_state, w_state_nxt;
    logic [NUM_CH-1:0]  r_rst, w_rst_nxt;
    logic               r_ready, w_ready_nxt;
    logic [2:0]         r_cause, w_cause_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;

    logic w_key_level, w_key_press;
    logic w_lock, w_unused_pll_press;
    logic w_trig_pll, w_trig_key, w_trig_sw, w_trig_wdt, w_trig_any;
    logic w_sources_ok;
    logic [2:0] w_trig_cause;

    rst_seq_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_async (key_n_i),
        .o_level (w_key_level),
        .o_press (w_key_press)
    );

    rst_seq_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (1)
    ) u_pll (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_async (pll_locked_i),
        .o_level (w_lock),
        .o_press (w_unused_pll_press)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wdt <= '0;
        end else if ((r_state != S_RUN) || wdt_kick_i || w_trig_any) begin
            r_wdt <= '0;
        end else begin
            r_wdt <= r_wdt + WDT_W'(1);
        end
    end

    assign w_trig_wdt = (r_state == S_RUN) && (r_wdt == WDT_LAST) && !wdt_kick_i;
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic w_unused_wdt_kick;

    assign w_unused_wdt_kick = wdt_kick_i;
    assign w_trig_wdt        = 1'b0;
`endif

    assign w_trig_pll   = !w_lock && (r_state != S_HOLD);
    assign w_trig_key   = w_key_press;
    assign w_trig_sw    = sw_rst_req_i && (r_state == S_RUN);
    assign w_trig_any   = w_trig_pll | w_trig_key | w_trig_sw | w_trig_wdt;
    assign w_trig_cause = w_trig_pll ? CAUSE_PLL :
                          w_trig_key ? CAUSE_KEY :
                          w_trig_sw  ? CAUSE_SW  : CAUSE_WDT;
    assign w_sources_ok = w_lock && w_key_level;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_trig_any) begin
            w_state_nxt = S_HOLD;
        end else begin
            case (r_state)
                S_HOLD:    if (w_sources_ok) w_state_nxt = S_POR;
                S_POR:     if (r_cnt == '0) w_state_nxt = S_RELEASE;
                S_RELEASE: if ((r_gap == '0) && (r_idx == IDX_LAST)) w_state_nxt = S_RUN;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_rst_nxt   = r_rst;
        w_ready_nxt = r_ready;
        w_cause_nxt = r_cause;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_idx_nxt   = r_idx;
        if (w_trig_any) begin
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_gap_nxt   = '0;
            w_idx_nxt   = '0;
            // While already holding, only a more important source may rewrite the cause.
            if ((r_state != S_HOLD) || (cause_rank(w_trig_cause) > cause_rank(r_cause)))
                w_cause_nxt = w_trig_cause;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_sources_ok)
                        w_cnt_nxt = (r_cause == CAUSE_SW) ? SW_LOAD : POR_LOAD;
                end
                S_POR: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_gap_nxt = '0;
                        w_idx_nxt = '0;
                    end
                end
                S_RELEASE: begin
                    if (r_gap == '0) begin
                        w_rst_nxt[r_idx] = 1'b0;
                        if (r_idx == IDX_LAST) begin
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                            w_gap_nxt = GAP_LOAD;
                        end
                    end else begin
                        w_gap_nxt = r_gap - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_cause <= CAUSE_POR;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_idx   <= '0;
        end else begin
            r_rst   <= w_rst_nxt;
            r_ready <= w_ready_nxt;
            r_cause <= w_cause_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign rst_o   = r_rst;
    assign rst_n_o = ~r_rst;
    assign ready_o = r_ready;
    assign cause_o = r_cause;

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb/tb_rst_seq_gen.sv - Directed self-checking bench for rst_seq_gen (watchdog expectations follow RST_SEQ_WDT_EN).
module tb_rst_seq_gen;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       key_n  = 1'b1;
    logic       lock   = 1'b1;
    logic       sw     = 1'b0;
    logic       kick   = 1'b0;
    logic [2:0] rst_o;
    logic [2:0] rst_n_o;
    logic       ready;
    logic [2:0] cause;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rst_seq_gen #(
        .NUM_CH          (3),
        .POR_CYCLES      (8),
        .SW_RST_CYCLES   (4),
        .STAGE_GAP       (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .WDT_CYCLES      (32)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .key_n_i      (key_n),
        .pll_locked_i (lock),
        .sw_rst_req_i (sw),
        .wdt_kick_i   (kick),
        .rst_o        (rst_o),
        .rst_n_o      (rst_n_o),
        .ready_o      (ready),
        .cause_o      (cause)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_rst, input logic e_ready,
                           input logic [2:0] e_cause);
        logic [2:0] e_rst_n;
        e_rst_n = ~e_rst;
        chk({tag, ".rst"},   {29'd0, rst_o},   {29'd0, e_rst});
        chk({tag, ".rst_n"}, {29'd0, rst_n_o}, {29'd0, e_rst_n});
        chk({tag, ".ready"}, {31'd0, ready},   {31'd0, e_ready});
        chk({tag, ".cause"}, {29'd0, cause},   {29'd0, e_cause});
    endtask

    initial begin
        step(3);
        chk_out("reset", 3'b111, 1'b0, 3'b000);

        rst_n = 1'b1;
        step(11); chk_out("pu_e11", 3'b111, 1'b0, 3'b000);
        step(1);  chk_out("pu_e12", 3'b110, 1'b0, 3'b000);
        step(3);  chk_out("pu_e15", 3'b110, 1'b0, 3'b000);
        step(1);  chk_out("pu_e16", 3'b100, 1'b0, 3'b000);
        step(3);  chk_out("pu_e19", 3'b100, 1'b0, 3'b000);
        step(1);  chk_out("pu_e20", 3'b000, 1'b1, 3'b000);

        for (int i = 0; i < 2; i++) begin
            key_n = 1'b0; step(3);
            key_n = 1'b1; step(4);
        end
        step(4);  chk_out("bounce", 3'b000, 1'b1, 3'b000);

        key_n = 1'b0;
        step(6);  chk_out("key_e5", 3'b000, 1'b1, 3'b000);
        step(1);  chk_out("key_e6", 3'b111, 1'b0, 3'b001);
        step(3);  chk_out("key_held", 3'b111, 1'b0, 3'b001);
        key_n = 1'b1;
        step(15); chk_out("key_rel_e14", 3'b111, 1'b0, 3'b001);
        step(1);  chk_out("key_rel_e15", 3'b110, 1'b0, 3'b001);
        step(4);  chk_out("key_rel_e19", 3'b100, 1'b0, 3'b001);
        step(4);  chk_out("key_rel_e23", 3'b000, 1'b1, 3'b001);

        lock = 1'b0; step(1);
        lock = 1'b1;
        step(1);  chk_out("pll_e1", 3'b000, 1'b1, 3'b001);
        step(1);  chk_out("pll_e2", 3'b111, 1'b0, 3'b010);
        step(9);  chk_out("pll_e11", 3'b111, 1'b0, 3'b010);
        step(1);  chk_out("pll_e12", 3'b110, 1'b0, 3'b010);
        step(8);  chk_out("pll_e20", 3'b000, 1'b1, 3'b010);

        sw = 1'b1; step(1); sw = 1'b0;
        chk_out("sw_e0", 3'b111, 1'b0, 3'b011);
        step(5);  chk_out("sw_e5", 3'b111, 1'b0, 3'b011);
        step(1);  chk_out("sw_e6", 3'b110, 1'b0, 3'b011);
        sw = 1'b1; step(1); sw = 1'b0;
        chk_out("sw_in_release", 3'b110, 1'b0, 3'b011);
        step(3);  chk_out("sw_e10", 3'b100, 1'b0, 3'b011);
        step(4);  chk_out("sw_e14", 3'b000, 1'b1, 3'b011);

        key_n = 1'b0; lock = 1'b0;
        step(3);  chk_out("both_e2", 3'b111, 1'b0, 3'b010);
        step(6);  chk_out("both_e8", 3'b111, 1'b0, 3'b010);
        key_n = 1'b1; lock = 1'b1;
        step(15); chk_out("both_rel_e14", 3'b111, 1'b0, 3'b010);
        step(1);  chk_out("both_rel_e15", 3'b110, 1'b0, 3'b010);

        step(2);
        #3 rst_n = 1'b0;
        #1 chk_out("async_rst", 3'b111, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        step(20); chk_out("pu2_e20", 3'b000, 1'b1, 3'b000);

        for (int i = 0; i < 3; i++) begin
            kick = 1'b1; step(1); kick = 1'b0;
            step(19); chk_out("wdt_kicked", 3'b000, 1'b1, 3'b000);
        end
        step(12); chk_out("wdt_e31", 3'b000, 1'b1, 3'b000);
        step(1);
`ifdef RST_SEQ_WDT_EN
        chk_out("wdt_e32", 3'b111, 1'b0, 3'b100);
`else
        chk_out("wdt_e32", 3'b000, 1'b1, 3'b000);
        step(20); chk_out("wdt_none", 3'b000, 1'b1, 3'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
Parametrised reset sequencer; successor to the fixed wb_rst/sdram_rst pair produced beside the PLL clock generator.
- Generates NUM_CH synchronous reset outputs, released in order (channel 0 first): e.g. bus fabric, then SDRAM controller, then CPU.
- Reset sources: power-on, debounced board key, PLL lock loss and a software request.
- Latches the cause of the last reset for firmware readback.
- Sits in the board top between the clock generator and the SoC.

Parameters:
- NUM_CH, 3, number of reset channels (1..8).
- POR_CYCLES, 1024, hold time after all sources are clear (>=1).
- SW_RST_CYCLES, 16, hold time used instead of POR_CYCLES when the cause is software (>=1).
- STAGE_GAP, 16, cycles between successive channel releases (>=1).
- SYNC_STAGES, 2, synchroniser depth for key_n_i and pll_locked_i (>=2).
- DEBOUNCE_CYCLES, 65536, consecutive stable synced cycles needed to accept a key level change (>=1).
- WDT_CYCLES, 2**24, watchdog timeout; used only with the optional feature.

Ports:
- wb_clk_i, in, 1: single clock; all logic in this domain.
- wb_rst_n_i, in, 1: asynchronous, active-low reset.
- key_n_i, in, 1: asynchronous board key, low = pressed.
- pll_locked_i, in, 1: asynchronous PLL lock flag.
- sw_rst_req_i, in, 1: synchronous one-cycle software reset request.
- wdt_kick_i, in, 1: synchronous watchdog kick; ignored unless the optional feature is compiled in.
- rst_o, out, NUM_CH: active-high synchronous resets.
- rst_n_o, out, NUM_CH: bitwise inverse of rst_o.
- ready_o, out, 1: high when all channels are released.
- cause_o, out, 3: cause of the last reset.
  - 000 POR, 001 key, 010 PLL loss, 011 software, 100 watchdog.

Behaviour:
- Reset state (wb_rst_n_i low, applied asynchronously):
  - rst_o all ones, rst_n_o all zeros, ready_o 0, cause_o 000.
  - FSM in S_HOLD; synchroniser flops 0; debounced key state = released; all counters 0.
- rst_o flops assert asynchronously on wb_rst_n_i and deassert only synchronously.
- key_n_i and pll_locked_i each pass through a SYNC_STAGES-flop synchroniser.
- Key debounce:
  - The debounced state flips only after DEBOUNCE_CYCLES consecutive cycles where the synced level differs from the current debounced state.
  - Any bounce clears the count.
- Triggers, evaluated every cycle; priority PLL > key > software > watchdog:
  - pll_loss: synced lock is 0 while the FSM is not in S_HOLD.
  - key: debounced press event (released to pressed).
  - sw: sw_rst_req_i high while in S_RUN; ignored in every other state.
- On any trigger:
  - Next edge: FSM goes to S_HOLD, all rst_o = 1, ready_o = 0, cause_o updated.
  - Latency is 1 cycle from the trigger condition.
  - A trigger in S_POR or S_RELEASE restarts the sequence.
- FSM states:
  - S_HOLD: waits until synced lock = 1 and debounced key = released. Then goes to S_POR and loads the counter with SW_RST_CYCLES-1 if cause_o = 011, otherwise POR_CYCLES-1.
  - S_POR: counter decrements. At 0, goes to S_RELEASE with idx = 0 and the gap counter = 0.
  - S_RELEASE: on entry to channel idx, clears rst_o[idx] on that edge. Then waits STAGE_GAP cycles before clearing idx+1. Clearing the last channel moves the FSM to S_RUN and sets ready_o on the same edge.
  - S_RUN: holds outputs; only triggers leave this state.
- Timing from reset release (edge 1 = first rising edge):
  - rst_o[0] falls at edge SYNC_STAGES+POR_CYCLES+2.
  - rst_o[k] falls at that edge + k*STAGE_GAP.
  - Holds when pll_locked_i and key_n_i are already high.
- Edge cases:
  - A held key keeps the block in S_HOLD.
  - A second trigger while in S_HOLD overwrites cause_o only if it has higher priority.
- Counter widths are $clog2 of max(POR_CYCLES, SW_RST_CYCLES), STAGE_GAP and DEBOUNCE_CYCLES, with no wrap.

Optional Feature:
- RST_SEQ_WDT_EN defined:
  - In S_RUN, a watchdog counter counts up; wdt_kick_i clears it to 0.
  - Reaching WDT_CYCLES-1 raises a watchdog trigger, cause 100.
  - The counter is held at 0 outside S_RUN.
- Undefined: no watchdog logic; wdt_kick_i is unconnected internally; cause 100 is never produced.

Decomposition:
- Package rst_seq_pkg:
  - FSM state enumeration (S_HOLD, S_POR, S_RELEASE, S_RUN).
  - Cause codes as named 3-bit constants.
- One sub-module, rst_seq_debounce: synchroniser plus debounce counter. Parameters SYNC_STAGES and DEBOUNCE_CYCLES; outputs are the level and a press pulse. Instantiated for the key.
- The PLL input uses the synchroniser only (DEBOUNCE_CYCLES=1).

Test Plan:
Bench parameters: NUM_CH=3, POR_CYCLES=8, SW_RST_CYCLES=4, STAGE_GAP=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WDT_CYCLES=32.
- Power-up: lock=1, key=1 -> rst_o[0] falls at edge 12, [1] at 16, [2] and ready_o at 20; cause_o = 000.
- Key bounce: 3-cycle low pulses -> no reset. A 10-cycle press -> all rst_o high 1 cycle after debounce completes; cause_o = 001; after release and re-debounce, release resumes after 8 POR cycles.
- PLL loss in S_RUN: drop lock for 1 cycle -> all rst_o high on edge SYNC_STAGES+1 after the drop; cause_o = 010; re-sequence after lock returns.
- Software request: sw_rst_req_i pulse in S_RUN -> reset; cause_o = 011; rst_o[0] releases 4 counter cycles after S_POR entry. The same pulse during S_RELEASE is ignored.
- Simultaneous key press and lock loss on the same cycle -> cause_o = 010. wb_rst_n_i low mid-S_RELEASE -> rst_o = 111 immediately (asynchronous), cause_o = 000.
- With RST_SEQ_WDT_EN: kick every 20 cycles -> no reset; stop kicking -> reset 32 cycles after the last kick, cause_o = 100. Without the macro -> no reset and wdt_kick_i has no effect.
